// File: rtl/receiver_tree_expand_if.sv
// Bus bundle for the receiver GGM tree expander: control, co-path seeds, PRG request/response, leaf stream.
interface receiver_tree_expand_if #(
  parameter int D = 3
);
  logic           start;
  logic [D-1:0]   alpha;
  logic           busy;
  logic           done;
  logic           cop_valid;
  logic           cop_ready;
  logic [127:0]   cop_data;
  logic           prg_req_valid;
  logic           prg_req_ready;
  logic [127:0]   prg_req_seed;
  logic           prg_rsp_valid;
  logic [127:0]   prg_rsp_left;
  logic [127:0]   prg_rsp_right;
  logic           leaf_valid;
  logic           leaf_ready;
  logic [D-1:0]   leaf_idx;
  logic [127:0]   leaf_data;
  logic           leaf_punct;

  modport master (
    output start, alpha, cop_valid, cop_data, prg_req_ready,
           prg_rsp_valid, prg_rsp_left, prg_rsp_right, leaf_ready,
    input  busy, done, cop_ready, prg_req_valid, prg_req_seed,
           leaf_valid, leaf_idx, leaf_data, leaf_punct
  );

  modport slave (
    input  start, alpha, cop_valid, cop_data, prg_req_ready,
           prg_rsp_valid, prg_rsp_left, prg_rsp_right, leaf_ready,
    output busy, done, cop_ready, prg_req_valid, prg_req_seed,
           leaf_valid, leaf_idx, leaf_data, leaf_punct
  );
endinterface

// File: rtl/receiver_tree_expand.sv
// Rebuilds all GGM leaves except alpha from co-path seeds via an external PRG, then streams them in order.
// PRG issue is credit-limited; leaves hold stable under leaf_ready backpressure; responses are never stalled.
module receiver_tree_expand #(
  parameter int D           = 3,
  parameter int PRG_CREDITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  receiver_tree_expand_if.slave bus
);
  localparam int N  = 1 << D;
  localparam int LW = $clog2(D + 1);
  localparam int OW = $clog2(PRG_CREDITS + 1);

  typedef enum logic [1:0] {IDLE, LOAD_COP, EXPAND, EMIT} state_t;
  typedef logic [127:0] seed_t;

  state_t        state_q, state_d;
  logic [D-1:0]  alpha_q, alpha_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [D:0]    i_q, i_d, r_q, r_d;
  logic [OW-1:0] out_q, out_d;
  logic [D-1:0]  k_q, k_d;
  logic          sel_q, sel_d, busy_q, busy_d, done_q, done_d;
  seed_t         mem_q [2][N];
  seed_t         mem_d [2][N];

  logic [D:0]    n_par, p_par, i_eff, r_eff;
  logic [D-1:0]  s_idx, w_idx;
  logic          req_vld, req_fire, rsp_take, punct;

  // In EXPAND lvl_q is the level being built: the parent level has n_par nodes and p_par is alpha's ancestor.
  always_comb begin
    n_par = (D+1)'(1) << (lvl_q - LW'(1));
    p_par = (D+1)'(alpha_q) >> (D - int'(lvl_q) + 1);
    s_idx = (alpha_q >> (D - int'(lvl_q))) ^ D'(1);
    i_eff = (i_q == p_par) ? i_q + (D+1)'(1) : i_q;
    r_eff = (r_q == p_par) ? r_q + (D+1)'(1) : r_q;
    w_idx = D'(r_eff << 1);
  end

  always_comb begin
    state_d = state_q;
    alpha_d = alpha_q;
    lvl_d   = lvl_q;
    i_d     = i_q;
    r_d     = r_q;
    out_d   = out_q;
    k_d     = k_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mem_d   = mem_q;
    req_vld  = 1'b0;
    req_fire = 1'b0;
    rsp_take = 1'b0;
    punct    = 1'b0;
    bus.cop_ready     = 1'b0;
    bus.prg_req_valid = 1'b0;
    bus.prg_req_seed  = '0;
    bus.leaf_valid    = 1'b0;
    bus.leaf_idx      = '0;
    bus.leaf_data     = '0;
    bus.leaf_punct    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          alpha_d = bus.alpha;
          lvl_d   = LW'(1);
          busy_d  = 1'b1;
          state_d = LOAD_COP;
        end
      end
      LOAD_COP: begin
        bus.cop_ready = 1'b1;
        if (bus.cop_valid) begin
          mem_d[~sel_q][s_idx] = bus.cop_data;
          sel_d = ~sel_q;
          if (lvl_q == LW'(D)) begin
            k_d     = '0;
            state_d = EMIT;
          end else begin
            lvl_d   = lvl_q + LW'(1);
            i_d     = '0;
            r_d     = '0;
            state_d = EXPAND;
          end
        end
      end
      EXPAND: begin
        req_vld  = (i_eff < n_par) && (out_q < OW'(PRG_CREDITS));
        req_fire = req_vld && bus.prg_req_ready;
        rsp_take = bus.prg_rsp_valid && (out_q != '0);
        bus.prg_req_valid = req_vld;
        bus.prg_req_seed  = req_vld ? mem_q[sel_q][i_eff[D-1:0]] : '0;
        i_d = req_fire ? i_eff + (D+1)'(1) : i_eff;
        if (rsp_take) begin
          mem_d[~sel_q][w_idx]          = bus.prg_rsp_left;
          mem_d[~sel_q][w_idx | D'(1)]  = bus.prg_rsp_right;
          r_d = r_eff + (D+1)'(1);
        end
        out_d = out_q + OW'(req_fire) - OW'(rsp_take);
        if (r_eff >= n_par) state_d = LOAD_COP;
      end
      EMIT: begin
        punct          = (k_q == alpha_q);
        bus.leaf_valid = 1'b1;
        bus.leaf_idx   = k_q;
        bus.leaf_punct = punct;
        bus.leaf_data  = punct ? '0 : mem_q[sel_q][k_q];
        if (bus.leaf_ready) begin
          if (k_q == D'(N - 1)) begin
            k_d     = '0;
            lvl_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            k_d = k_q + D'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      alpha_q <= '0;
      lvl_q   <= '0;
      i_q     <= '0;
      r_q     <= '0;
      out_q   <= '0;
      k_q     <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < N; e++) mem_q[b][e] <= '0;
      end
    end else begin
      state_q <= state_d;
      alpha_q <= alpha_d;
      lvl_q   <= lvl_d;
      i_q     <= i_d;
      r_q     <= r_d;
      out_q   <= out_d;
      k_q     <= k_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_receiver_tree_expand.sv
// Bench: two DUTs (4 credits, 1 credit) each with a 29-cycle shift PRG model; table-driven runs plus corner sequences.
module tb_receiver_tree_expand;
  localparam int D = 3;

  typedef struct { int due; logic [127:0] seed; } prg_t;
  typedef struct { logic [2:0] idx; logic [127:0] data; logic punct; } leaf_t;
  typedef struct {
    int                dsel;
    bit                tog;
    logic [2:0]        alpha;
    logic [0:2][127:0] cop;
    logic [0:7][127:0] leaf;
    logic [0:3][127:0] req;
  } vec_t;

  logic clk, rst;
  int   cyc = 0;

  logic [1:0]             start_v, cop_valid_v, leaf_ready_v;
  logic [1:0][2:0]        alpha_v;
  logic [1:0][127:0]      cop_data_v;
  logic [1:0]             cop_ready_v, req_valid_v, rsp_valid_v, leaf_valid_v, leaf_punct_v, busy_v, done_v;
  logic [1:0][127:0]      req_seed_v, leaf_data_v;
  logic [1:0][2:0]        leaf_idx_v;

  int checks = 0, errors = 0;
  int cur_dut = 0, md, tcnt = 0;
  bit toggle_mode = 0, mon_en = 0, held_vld = 0;
  int req_cnt, out_cnt, max_out, leaf_cnt, done_cnt;
  leaf_t held, le;
  leaf_t leaf_q[$];
  logic [127:0] req_q[$];
  logic [127:0] rq;
  vec_t vecs [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    receiver_tree_expand_if #(.D(D)) bus ();
    prg_t pq[$];
    assign bus.start         = start_v[g];
    assign bus.alpha         = alpha_v[g];
    assign bus.cop_valid     = cop_valid_v[g];
    assign bus.cop_data      = cop_data_v[g];
    assign bus.leaf_ready    = leaf_ready_v[g];
    assign bus.prg_req_ready = 1'b1;
    assign cop_ready_v[g]  = bus.cop_ready;
    assign req_valid_v[g]  = bus.prg_req_valid;
    assign req_seed_v[g]   = bus.prg_req_seed;
    assign rsp_valid_v[g]  = bus.prg_rsp_valid;
    assign leaf_valid_v[g] = bus.leaf_valid;
    assign leaf_idx_v[g]   = bus.leaf_idx;
    assign leaf_data_v[g]  = bus.leaf_data;
    assign leaf_punct_v[g] = bus.leaf_punct;
    assign busy_v[g]       = bus.busy;
    assign done_v[g]       = bus.done;

    receiver_tree_expand #(.D(D), .PRG_CREDITS(g == 0 ? 4 : 1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    // Request seen here fires at edge cyc+1; its response must be sampled at edge cyc+30.
    always @(negedge clk) begin
      if (rst) begin
        pq.delete();
        bus.prg_rsp_valid = 1'b0;
        bus.prg_rsp_left  = '0;
        bus.prg_rsp_right = '0;
      end else begin
        if (bus.prg_req_valid) pq.push_back('{due: cyc + 30, seed: bus.prg_req_seed});
        if (pq.size() != 0 && pq[0].due == cyc + 1) begin
          bus.prg_rsp_valid = 1'b1;
          bus.prg_rsp_left  = pq[0].seed << 1;
          bus.prg_rsp_right = (pq[0].seed << 1) | 128'd1;
          void'(pq.pop_front());
        end else begin
          bus.prg_rsp_valid = 1'b0;
          bus.prg_rsp_left  = '0;
          bus.prg_rsp_right = '0;
        end
      end
    end
  end

  // leaf_ready pattern 1,0,0,1 on the active DUT when toggling, otherwise always ready.
  always @(negedge clk) begin
    tcnt++;
    for (int g = 0; g < 2; g++)
      leaf_ready_v[g] = (toggle_mode && g == cur_dut) ? ((tcnt % 4 == 0) || (tcnt % 4 == 3)) : 1'b1;
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  always @(negedge clk) begin
    #3;
    if (mon_en) begin
      md = cur_dut;
      if (req_valid_v[md]) begin
        req_cnt++;
        if (req_q.size() == 0) timeout("req_extra");
        else begin
          rq = req_q.pop_front();
          chk("req_seed", req_seed_v[md], rq);
        end
      end
      out_cnt = out_cnt + int'(req_valid_v[md]) - ((rsp_valid_v[md] && out_cnt > 0) ? 1 : 0);
      if (out_cnt > max_out) max_out = out_cnt;
      if (leaf_valid_v[md]) begin
        if (held_vld) begin
          chk("hold_idx", 128'(leaf_idx_v[md]), 128'(held.idx));
          chk("hold_data", leaf_data_v[md], held.data);
          chk("hold_punct", 128'(leaf_punct_v[md]), 128'(held.punct));
        end
        if (leaf_ready_v[md]) begin
          held_vld = 0;
          leaf_cnt++;
          if (leaf_q.size() == 0) timeout("leaf_extra");
          else begin
            le = leaf_q.pop_front();
            chk("leaf_idx", 128'(leaf_idx_v[md]), 128'(le.idx));
            chk("leaf_data", leaf_data_v[md], le.data);
            chk("leaf_punct", 128'(leaf_punct_v[md]), 128'(le.punct));
          end
        end else begin
          held_vld = 1;
          held = '{idx: leaf_idx_v[md], data: leaf_data_v[md], punct: leaf_punct_v[md]};
        end
      end
      if (done_v[md]) begin
        done_cnt++;
        chk("done_after_last_leaf", 128'(leaf_cnt), 128'd8);
        chk("busy_at_done", 128'(busy_v[md]), 128'd0);
      end
    end
  end

  task automatic begin_run(input int d, input bit tog);
    cur_dut = d; toggle_mode = tog;
    req_cnt = 0; out_cnt = 0; max_out = 0; leaf_cnt = 0; done_cnt = 0; held_vld = 0;
    leaf_q.delete(); req_q.delete();
    mon_en = 1;
  endtask

  task automatic push_exp(input vec_t v);
    for (int j = 0; j < 8; j++)
      leaf_q.push_back('{idx: 3'(j), data: v.leaf[j], punct: (3'(j) == v.alpha)});
    for (int j = 0; j < 4; j++) req_q.push_back(v.req[j]);
  endtask

  task automatic start_run(input int d, input logic [2:0] a);
    start_v[d] = 1'b1; alpha_v[d] = a;
    @(negedge clk);
    start_v[d] = 1'b0;
  endtask

  task automatic feed_cop(input int d, input logic [127:0] v);
    int n = 0;
    logic hs = 1'b0;
    cop_valid_v[d] = 1'b1; cop_data_v[d] = v;
    while (!hs && n < 2000) begin
      #3 hs = cop_ready_v[d];
      @(negedge clk);
      n++;
    end
    cop_valid_v[d] = 1'b0; cop_data_v[d] = '0;
    if (!hs) timeout("cop_handshake");
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == 0) timeout("done");
  endtask

  task automatic end_checks(input int cred);
    repeat (5) @(negedge clk);
    chk("req_count", 128'(req_cnt), 128'd4);
    chk("outstanding_within_credits", 128'(max_out <= cred), 128'd1);
    chk("leaf_count", 128'(leaf_cnt), 128'd8);
    chk("done_pulses", 128'(done_cnt), 128'd1);
    chk("leaf_queue_drained", 128'(leaf_q.size()), 128'd0);
    chk("busy_after_done", 128'(busy_v[cur_dut]), 128'd0);
  endtask

  task automatic check_reset_outputs(input int d);
    #3;
    chk("rst_busy", 128'(busy_v[d]), 128'd0);
    chk("rst_done", 128'(done_v[d]), 128'd0);
    chk("rst_cop_ready", 128'(cop_ready_v[d]), 128'd0);
    chk("rst_req_valid", 128'(req_valid_v[d]), 128'd0);
    chk("rst_req_seed", req_seed_v[d], 128'd0);
    chk("rst_leaf_valid", 128'(leaf_valid_v[d]), 128'd0);
    chk("rst_leaf_idx", 128'(leaf_idx_v[d]), 128'd0);
    chk("rst_leaf_data", leaf_data_v[d], 128'd0);
    chk("rst_leaf_punct", 128'(leaf_punct_v[d]), 128'd0);
  endtask

  task automatic run_row(input vec_t v);
    begin_run(v.dsel, v.tog);
    push_exp(v);
    start_run(v.dsel, v.alpha);
    for (int j = 0; j < 3; j++) feed_cop(v.dsel, v.cop[j]);
    wait_done();
    end_checks(v.dsel == 0 ? 4 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic got;
    vecs[0] = '{dsel: 0, tog: 0, alpha: 3'd5, cop: {128'h1, 128'h30, 128'h40},
                leaf: {128'h4, 128'h5, 128'h6, 128'h7, 128'h40, 128'h0, 128'h60, 128'h61},
                req: {128'h1, 128'h2, 128'h3, 128'h30}};
    vecs[1] = '{dsel: 0, tog: 0, alpha: 3'd0, cop: {128'h1, 128'h1, 128'h1},
                leaf: {128'h0, 128'h1, 128'h2, 128'h3, 128'h4, 128'h5, 128'h6, 128'h7},
                req: {128'h1, 128'h1, 128'h2, 128'h3}};
    vecs[2] = '{dsel: 0, tog: 0, alpha: 3'd7, cop: {128'h10, 128'h20, 128'h30},
                leaf: {128'h40, 128'h41, 128'h42, 128'h43, 128'h40, 128'h41, 128'h30, 128'h0},
                req: {128'h10, 128'h20, 128'h21, 128'h20}};
    vecs[3] = vecs[0];
    vecs[3].dsel = 1;
    vecs[4] = vecs[0];
    vecs[4].tog = 1;

    start_v = '0; cop_valid_v = '0; alpha_v = '0; cop_data_v = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 5; r++) run_row(vecs[r]);

    // Reset while level 2 is expanding, then a clean rerun.
    begin_run(0, 0);
    mon_en = 0;
    start_run(0, 3'd5);
    feed_cop(0, 128'h1);
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      #3 got = req_valid_v[0];
      @(negedge clk);
      n++;
    end
    if (!got) timeout("expand_entry");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs(0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_row(vecs[0]);

    // A second start mid-run must not disturb alpha or the result.
    begin_run(0, 0);
    push_exp(vecs[0]);
    start_run(0, 3'd5);
    feed_cop(0, 128'h1);
    start_v[0] = 1'b1; alpha_v[0] = 3'd2;
    @(negedge clk);
    start_v[0] = 1'b0;
    #3 chk("busy_during_restart", 128'(busy_v[0]), 128'd1);
    @(negedge clk);
    feed_cop(0, 128'h30);
    feed_cop(0, 128'h40);
    wait_done();
    end_checks(4);

    // co-path valid while idle is ignored.
    mon_en = 0;
    cop_valid_v[0] = 1'b1; cop_data_v[0] = 128'hdead;
    for (int j = 0; j < 3; j++) begin
      #3;
      chk("cop_ready_idle", 128'(cop_ready_v[0]), 128'd0);
      chk("busy_idle", 128'(busy_v[0]), 128'd0);
      @(negedge clk);
    end
    cop_valid_v[0] = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
